phy_traffic_gen: RTL and testbench

PHY_TRAFFIC_GEN -- requirements
Module: phy_traffic_gen

---
 rtl/phy_traffic_gen_pkg.sv | 18 +
 rtl/prbs31_gen.sv | 41 ++++
 rtl/phy_traffic_gen.sv | 148 ++++++++++++++
 tb/tb_phy_traffic_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_traffic_gen_pkg.sv
// Shared PHY traffic-generator types: pattern mode encodings and FSM states.
package phy_traffic_gen_pkg;

  typedef enum logic [1:0] {
    ModeCounter = 2'd0,
    ModePrbs    = 2'd1,
    ModeFixed   = 2'd2,
    ModeWalk    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StGap  = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/prbs31_gen.sv
// Parallel PRBS31 (x^31 + x^28 + 1) generator, DATA_BUS_WIDTH bits per step.
// data is the word produced by stepping from the current state (or from the
// seed when load is high); load/advance commit that step into the state.
// The first generated bit lands in the MSB of data.
module prbs31_gen #(
  parameter int unsigned DATA_BUS_WIDTH = 32,
  parameter logic [31:0] PRBS_SEED      = 32'h0000_0001
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      advance,
  output logic [DATA_BUS_WIDTH-1:0] data
);

  logic [30:0] state_q;
  logic [30:0] lfsr;
  logic        fb;

  // Step the LFSR DATA_BUS_WIDTH times and collect the feedback bits.
  always_comb begin
    lfsr = load ? PRBS_SEED[30:0] : state_q;
    data = '0;
    fb   = 1'b0;
    for (int i = 0; i < int'(DATA_BUS_WIDTH); i++) begin
      fb   = lfsr[30] ^ lfsr[27];
      lfsr = {lfsr[29:0], fb};
      data = {data[DATA_BUS_WIDTH-2:0], fb};
    end
  end

  // State register; reset and load both return to the seed trajectory.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PRBS_SEED[30:0];
    end else if (load || advance) begin
      state_q <= lfsr;
    end
  end

endmodule

// File: rtl/phy_traffic_gen.sv
// PHY transmit traffic generator: bursts of counter / PRBS31 / fixed /
// walking-one words with a ready/enable handshake and optional idle gaps.
module phy_traffic_gen
  import phy_traffic_gen_pkg::*;
#(
  parameter int unsigned DATA_BUS_WIDTH = 32,
  parameter logic [31:0] PRBS_SEED      = 32'h0000_0001
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic [1:0]                mode,
  input  logic [DATA_BUS_WIDTH-1:0] fixed_pattern,
  input  logic [15:0]               burst_len,
  input  logic [7:0]                gap_len,
  input  logic                      tx_ready,
  output logic [DATA_BUS_WIDTH-1:0] Data_in,
  output logic                      enable,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               word_count
);

  localparam logic [DATA_BUS_WIDTH-1:0] One = {{(DATA_BUS_WIDTH-1){1'b0}}, 1'b1};

  state_e                    state_q, state_d;
  mode_e                     mode_q, mode_d;
  logic [15:0]               burst_q, burst_d;
  logic [7:0]                gap_q, gap_d;
  logic [7:0]                gap_cnt_q, gap_cnt_d;
  logic                      stop_pend_q, stop_pend_d;
  logic [DATA_BUS_WIDTH-1:0] data_q, data_d;
  logic [31:0]               count_q, count_d;
  logic                      prbs_load, prbs_adv;
  logic [DATA_BUS_WIDTH-1:0] prbs_data;

  prbs31_gen #(
    .DATA_BUS_WIDTH (DATA_BUS_WIDTH),
    .PRBS_SEED      (PRBS_SEED)
  ) u_prbs (
    .clk     (clk),
    .rst     (rst),
    .load    (prbs_load),
    .advance (prbs_adv),
    .data    (prbs_data)
  );

  // Next-state, config latch and pattern sequencing.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    burst_d     = burst_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    stop_pend_d = stop_pend_q;
    data_d      = data_q;
    count_d     = count_q;
    prbs_load   = 1'b0;
    prbs_adv    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StSend;
          mode_d      = mode_e'(mode);
          burst_d     = burst_len;
          gap_d       = gap_len;
          count_d     = '0;
          stop_pend_d = 1'b0;
          prbs_load   = 1'b1;
          unique case (mode_e'(mode))
            ModeCounter: data_d = '0;
            ModePrbs:    data_d = prbs_data;
            ModeFixed:   data_d = fixed_pattern;
            ModeWalk:    data_d = One;
            default:     data_d = '0;
          endcase
        end
      end
      StSend: begin
        if (stop) stop_pend_d = 1'b1;
        if (tx_ready) begin
          count_d  = count_q + 32'd1;
          prbs_adv = (mode_q == ModePrbs);
          unique case (mode_q)
            ModeCounter: data_d = data_q + One;
            ModePrbs:    data_d = prbs_data;
            ModeFixed:   data_d = data_q;
            ModeWalk:    data_d = (data_q << 1) | (data_q >> (DATA_BUS_WIDTH - 1));
            default:     data_d = data_q;
          endcase
          // A stop seen this cycle or while the word was pending ends the burst now.
          if (((burst_q != 16'd0) && (count_d == {16'd0, burst_q})) || stop || stop_pend_q) begin
            state_d = StDone;
          end else if (gap_q != 8'd0) begin
            state_d   = StGap;
            gap_cnt_d = gap_q;
          end
        end
      end
      StGap: begin
        if (stop) begin
          state_d = StDone;
        end else if (gap_cnt_q <= 8'd1) begin
          state_d = StSend;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers; rst wins over any concurrent start/stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= ModeCounter;
      burst_q     <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
      data_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      burst_q     <= burst_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      stop_pend_q <= stop_pend_d;
      data_q      <= data_d;
      count_q     <= count_d;
    end
  end

  // Outputs decode straight from registered state.
  always_comb begin
    Data_in    = data_q;
    enable     = (state_q == StSend);
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
    word_count = count_q;
  end

endmodule

// File: tb/tb_phy_traffic_gen.sv
// Directed bench for phy_traffic_gen: vector table plus multi-cycle sequences.
module tb_phy_traffic_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] fixed_pattern = 32'h0;
  logic [15:0] burst_len = 16'd0;
  logic [7:0]  gap_len = 8'd0;
  logic        tx_ready = 1'b0;
  logic [31:0] Data_in;
  logic        enable;
  logic        busy;
  logic        done;
  logic [31:0] word_count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_prbs [8];

  phy_traffic_gen #(
    .DATA_BUS_WIDTH (32),
    .PRBS_SEED      (32'h0000_0001)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .mode          (mode),
    .fixed_pattern (fixed_pattern),
    .burst_len     (burst_len),
    .gap_len       (gap_len),
    .tx_ready      (tx_ready),
    .Data_in       (Data_in),
    .enable        (enable),
    .busy          (busy),
    .done          (done),
    .word_count    (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        stop;
    logic        rdy;
    logic [1:0]  mode;
    logic [31:0] fixed;
    logic [15:0] burst;
    logic [7:0]  gap;
    logic        en;
    logic        busy;
    logic        done;
    logic        chk_data;
    logic [31:0] data;
    logic [31:0] count;
  } vec_t;

  vec_t vec [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic [31:0] exp_count);
    check({tag, " enable"}, {31'd0, enable}, 32'd0);
    check({tag, " busy"}, {31'd0, busy}, 32'd0);
    check({tag, " done"}, {31'd0, done}, 32'd0);
    check({tag, " word_count"}, word_count, exp_count);
  endtask

  task automatic begin_burst(input logic [1:0] m, input logic [31:0] fx, input logic [15:0] bl,
                             input logic [7:0] gl);
    start = 1'b1; mode = m; fixed_pattern = fx; burst_len = bl; gap_len = gl;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [30:0] st;
    logic        fb;
    logic [31:0] w;

    // Software PRBS31 model from seed 1; first generated bit is the word MSB.
    st = 31'd1;
    for (int k = 0; k < 8; k++) begin
      w = 32'h0;
      for (int i = 0; i < 32; i++) begin
        fb = st[30] ^ st[27];
        st = {st[29:0], fb};
        w  = {w[30:0], fb};
      end
      exp_prbs[k] = w;
    end

    //          start stop rdy mode fixed         burst gap   en busy done chk data          count
    vec[0]  = '{1'b1, 1'b0, 1'b1, 2'd0, 32'h0,        16'd4, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0,         32'd0};
    vec[1]  = '{1'b0, 1'b0, 1'b1, 2'd3, 32'hFFFF,     16'd1, 8'd7, 1'b1, 1'b1, 1'b0, 1'b1, 32'd1,         32'd1};
    vec[2]  = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        16'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd2,         32'd2};
    vec[3]  = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        16'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd3,         32'd3};
    vec[4]  = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        16'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,         32'd4};
    vec[5]  = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,         32'd4};
    vec[6]  = '{1'b1, 1'b0, 1'b0, 2'd2, 32'hA5A55A5A, 16'd2, 8'd3, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA5A55A5A, 32'd0};
    vec[7]  = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        16'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0,         32'd1};
    vec[8]  = '{1'b1, 1'b0, 1'b1, 2'd0, 32'h0,        16'd9, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0,         32'd1};
    vec[9]  = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        16'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0,         32'd1};
    vec[10] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        16'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA5A55A5A, 32'd1};
    vec[11] = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        16'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,         32'd2};
    vec[12] = '{1'b1, 1'b0, 1'b1, 2'd0, 32'h0,        16'd4, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,         32'd2};
    vec[13] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,         32'd2};

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("reset Data_in", Data_in, 32'd0);
    check_idle("reset", 32'd0);
    rst = 1'b0;

    // Counter burst, then fixed burst with gaps; starts outside IDLE ignored
    for (int v = 0; v < 14; v++) begin
      start = vec[v].start; stop = vec[v].stop; tx_ready = vec[v].rdy; mode = vec[v].mode;
      fixed_pattern = vec[v].fixed; burst_len = vec[v].burst; gap_len = vec[v].gap;
      tick();
      check($sformatf("vec%0d enable", v), {31'd0, enable}, {31'd0, vec[v].en});
      check($sformatf("vec%0d busy", v), {31'd0, busy}, {31'd0, vec[v].busy});
      check($sformatf("vec%0d done", v), {31'd0, done}, {31'd0, vec[v].done});
      check($sformatf("vec%0d word_count", v), word_count, vec[v].count);
      if (vec[v].chk_data) check($sformatf("vec%0d Data_in", v), Data_in, vec[v].data);
    end
    start = 1'b0;

    // Walking one across 33 words
    tx_ready = 1'b1;
    begin_burst(2'd3, 32'h0, 16'd33, 8'd0);
    for (int i = 0; i < 33; i++) begin
      check($sformatf("walk%0d enable", i), {31'd0, enable}, 32'd1);
      check($sformatf("walk%0d Data_in", i), Data_in, 32'h1 << (i % 32));
      tick();
    end
    check("walk done", {31'd0, done}, 32'd1);
    check("walk word_count", word_count, 32'd33);
    tick();
    check_idle("walk after", 32'd33);

    // PRBS31 with a 5-cycle stall on word 2
    tx_ready = 1'b0;
    begin_burst(2'd1, 32'h0, 16'd4, 8'd0);
    check("prbs w0", Data_in, exp_prbs[0]);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("prbs stall%0d Data_in", i), Data_in, exp_prbs[1]);
      check($sformatf("prbs stall%0d enable", i), {31'd0, enable}, 32'd1);
      tick();
    end
    check("prbs w1 after stall", Data_in, exp_prbs[1]);
    tx_ready = 1'b1;
    tick();
    check("prbs w2", Data_in, exp_prbs[2]);
    tick();
    check("prbs w3", Data_in, exp_prbs[3]);
    tick();
    check("prbs done", {31'd0, done}, 32'd1);
    check("prbs word_count", word_count, 32'd4);
    tick();

    // Continuous burst, stop while a word is pending
    begin_burst(2'd0, 32'h0, 16'd0, 8'd0);
    tick();
    tick();
    check("stop pre Data_in", Data_in, 32'd2);
    tx_ready = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop pend enable", {31'd0, enable}, 32'd1);
    check("stop pend Data_in", Data_in, 32'd2);
    tick();
    check("stop hold enable", {31'd0, enable}, 32'd1);
    check("stop hold Data_in", Data_in, 32'd2);
    tx_ready = 1'b1;
    tick();
    check("stop done", {31'd0, done}, 32'd1);
    check("stop enable", {31'd0, enable}, 32'd0);
    check("stop word_count", word_count, 32'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stop after%0d enable", i), {31'd0, enable}, 32'd0);
    end

    // Stop asserted during GAP
    begin_burst(2'd0, 32'h0, 16'd0, 8'd2);
    tick();
    check("gapstop in gap", {31'd0, enable}, 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("gapstop done", {31'd0, done}, 32'd1);
    check("gapstop word_count", word_count, 32'd1);
    tick();
    check_idle("gapstop after", 32'd1);

    // Reset in GAP dominates start/stop; PRBS replays from seed
    begin_burst(2'd1, 32'h0, 16'd10, 8'd5);
    tick();
    tick();
    check("rstgap busy", {31'd0, busy}, 32'd1);
    rst = 1'b1; start = 1'b1; stop = 1'b1;
    tick();
    check("rstgap Data_in", Data_in, 32'd0);
    check_idle("rstgap", 32'd0);
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    tick();
    check_idle("rstgap release", 32'd0);
    begin_burst(2'd1, 32'h0, 16'd2, 8'd0);
    check("replay w0", Data_in, exp_prbs[0]);
    check("replay enable", {31'd0, enable}, 32'd1);
    tick();
    check("replay w1", Data_in, exp_prbs[1]);
    tick();
    check("replay done", {31'd0, done}, 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
